// File: rtl/issue_fifo.sv
// Dual-slot instruction issue queue: up to two {pc, inst} pushes and up to two
// pops per cycle over a circular buffer, with flush and issue-stall control.
module issue_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       w_ena_1,
  input  logic                       w_ena_2,
  input  logic [31:0]                w_pc_1,
  input  logic [31:0]                w_inst_1,
  input  logic [31:0]                w_pc_2,
  input  logic [31:0]                w_inst_2,
  input  logic [1:0]                 pop_cnt,
  output logic                       fifo_o_valid_1,
  output logic                       fifo_o_valid_2,
  output logic [31:0]                fifo_o_pc_1,
  output logic [31:0]                fifo_o_inst_1,
  output logic [31:0]                fifo_o_pc_2,
  output logic [31:0]                fifo_o_inst_2,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr_nxt1;
  logic [AW-1:0] wptr_nxt1;
  logic [1:0]    push_k;
  logic [1:0]    pop_p;
  logic [CW-1:0] free_slots;
  logic          push_ok;
  logic [63:0]   head_0;
  logic [63:0]   head_1;

  // Clamp the requested pop to 2 and to what is actually stored; stall blocks it.
  function automatic logic [1:0] eff_pop(input logic [1:0] req,
                                         input logic [CW-1:0] cnt,
                                         input logic hold);
    logic [1:0] r;
    r = (req == 2'd3) ? 2'd2 : req;
    if (hold)
      r = 2'd0;
    else if (cnt < {{(CW-2){1'b0}}, r})
      r = cnt[1:0];
    return r;
  endfunction

  assign rptr_nxt1  = rptr + AW'(1);
  assign wptr_nxt1  = wptr + AW'(1);
  assign push_k     = {1'b0, w_ena_1} + {1'b0, w_ena_2};
  assign free_slots = FULL_CNT - count;
  assign push_ok    = (free_slots >= {{(CW-2){1'b0}}, push_k});
  assign pop_p      = eff_pop(pop_cnt, count, stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr <= rptr + AW'(pop_p);
      if (push_ok) begin
        wptr  <= wptr + AW'(push_k);
        count <= count + {{(CW-2){1'b0}}, push_k} - {{(CW-2){1'b0}}, pop_p};
      end else begin
        count <= count - {{(CW-2){1'b0}}, pop_p};
      end
    end
  end

  // Storage is left unreset; readers only see it through the valid masks.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      if (w_ena_1 && w_ena_2) begin
        mem[wptr]      <= {w_pc_1, w_inst_1};
        mem[wptr_nxt1] <= {w_pc_2, w_inst_2};
      end else if (w_ena_1) begin
        mem[wptr] <= {w_pc_1, w_inst_1};
      end else if (w_ena_2) begin
        mem[wptr] <= {w_pc_2, w_inst_2};
      end
    end
  end

  assign fifo_o_valid_1 = (count >= CW'(1));
  assign fifo_o_valid_2 = (count >= CW'(2));
  assign head_0         = fifo_o_valid_1 ? mem[rptr]      : 64'd0;
  assign head_1         = fifo_o_valid_2 ? mem[rptr_nxt1] : 64'd0;
  assign fifo_o_pc_1    = head_0[63:32];
  assign fifo_o_inst_1  = head_0[31:0];
  assign fifo_o_pc_2    = head_1[63:32];
  assign fifo_o_inst_2  = head_1[31:0];
  assign fifo_full      = (free_slots < CW'(2));
  assign fifo_empty     = (count == '0);

endmodule

// File: tb/tb_issue_fifo.sv
// Scoreboard bench for issue_fifo: a queue of expected {pc, inst} entries is
// filled on accepted pushes and consumed on effective pops.
module tb_issue_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        w_ena_1;
  logic        w_ena_2;
  logic [31:0] w_pc_1;
  logic [31:0] w_inst_1;
  logic [31:0] w_pc_2;
  logic [31:0] w_inst_2;
  logic [1:0]  pop_cnt;
  logic        fifo_o_valid_1;
  logic        fifo_o_valid_2;
  logic [31:0] fifo_o_pc_1;
  logic [31:0] fifo_o_inst_1;
  logic [31:0] fifo_o_pc_2;
  logic [31:0] fifo_o_inst_2;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  count;

  logic [63:0] sb [$];
  int          tests  = 0;
  int          errors = 0;
  int          seq    = 0;

  issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .w_ena_1(w_ena_1), .w_ena_2(w_ena_2),
    .w_pc_1(w_pc_1), .w_inst_1(w_inst_1), .w_pc_2(w_pc_2), .w_inst_2(w_inst_2),
    .pop_cnt(pop_cnt),
    .fifo_o_valid_1(fifo_o_valid_1), .fifo_o_valid_2(fifo_o_valid_2),
    .fifo_o_pc_1(fifo_o_pc_1), .fifo_o_inst_1(fifo_o_inst_1),
    .fifo_o_pc_2(fifo_o_pc_2), .fifo_o_inst_2(fifo_o_inst_2),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = sb.size();
    check("count",   64'(count), 64'(n));
    check("valid_1", 64'(fifo_o_valid_1), 64'(n >= 1));
    check("valid_2", 64'(fifo_o_valid_2), 64'(n >= 2));
    check("empty",   64'(fifo_empty), 64'(n == 0));
    check("full",    64'(fifo_full), 64'((DEPTH - n) < 2));
    check("head_0",  {fifo_o_pc_1, fifo_o_inst_1}, (n >= 1) ? sb[0] : 64'd0);
    check("head_1",  {fifo_o_pc_2, fifo_o_inst_2}, (n >= 2) ? sb[1] : 64'd0);
  endtask

  // Called at a falling edge: check, drive, advance one clock, update model.
  task automatic cyc(input logic e1, input logic e2,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input logic [31:0] a2, input logic [31:0] b2,
                     input logic [1:0] pc, input logic st, input logic fl);
    int n, k, p;
    bit acc;
    check_outputs();
    w_ena_1 = e1; w_ena_2 = e2;
    w_pc_1 = a1; w_inst_1 = b1; w_pc_2 = a2; w_inst_2 = b2;
    pop_cnt = pc; stall = st; flush = fl;
    n   = sb.size();
    k   = int'(e1) + int'(e2);
    acc = (DEPTH - n) >= k;
    p   = (pc == 2'd3) ? 2 : int'(pc);
    if (p > n) p = n;
    if (st) p = 0;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      repeat (p) void'(sb.pop_front());
      if (acc) begin
        if (e1) sb.push_back({a1, b1});
        if (e2) sb.push_back({a2, b2});
      end
    end
    @(negedge clk);
    w_ena_1 = 1'b0; w_ena_2 = 1'b0; pop_cnt = 2'd0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic cyc_gen(input logic e1, input logic e2, input logic [1:0] pc,
                         input logic st, input logic fl);
    logic [31:0] a1, a2;
    a1 = 32'h0004_0000 + 32'(seq) * 8;
    a2 = a1 + 32'd4;
    seq++;
    cyc(e1, e2, a1, ~a1, a2, ~a2, pc, st, fl);
  endtask

  initial begin
    logic [31:0] first_pc;
    rst = 1'b0; flush = 1'b0; stall = 1'b0; w_ena_1 = 1'b0; w_ena_2 = 1'b0;
    w_pc_1 = '0; w_inst_1 = '0; w_pc_2 = '0; w_inst_2 = '0; pop_cnt = 2'd0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Basic dual push
    cyc(1'b1, 1'b1, 32'h1000, 32'h2401_0001, 32'h1004, 32'h2402_0002, 2'd0, 1'b0, 1'b0);
    check("r031_count", 64'(count), 64'd2);
    check("r031_pc1",   64'(fifo_o_pc_1), 64'h1000);
    check("r031_inst1", 64'(fifo_o_inst_1), 64'h2401_0001);
    check("r031_pc2",   64'(fifo_o_pc_2), 64'h1004);
    check("r031_inst2", 64'(fifo_o_inst_2), 64'h2402_0002);

    // Fill and overflow rejection
    cyc_gen(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (3) cyc_gen(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    check("r032_count6", 64'(count), 64'd6);
    check("r032_full6",  64'(fifo_full), 64'd0);
    cyc_gen(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("r032_full7",  64'(fifo_full), 64'd1);
    cyc_gen(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    check("r032_reject", 64'(count), 64'd7);
    cyc_gen(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("r032_single_last", 64'(count), 64'd8);

    // Stall versus pop with simultaneous push
    cyc_gen(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc_gen(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    first_pc = fifo_o_pc_1;
    cyc_gen(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    check("r033_stall_count", 64'(count), 64'd3);
    check("r033_stall_head",  64'(fifo_o_pc_1), 64'(first_pc));
    cyc_gen(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc_gen(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc_gen(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    check("r033_pop_count", 64'(count), 64'd2);
    check("r033_pop_head",  64'(fifo_o_pc_1), 64'(32'h0004_0000 + 32'(seq - 1) * 8));

    // Full-rate streaming across pointer wrap, then drain with pop_cnt=3
    cyc_gen(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (4) cyc_gen(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (6) cyc_gen(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    repeat (5) cyc_gen(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    check("r034_drained", 64'(fifo_empty), 64'd1);

    // Flush beats stall and push
    repeat (2) cyc_gen(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc_gen(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("r035_count5", 64'(count), 64'd5);
    cyc_gen(1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
    check("r035_count", 64'(count), 64'd0);
    check("r035_empty", 64'(fifo_empty), 64'd1);
    check("r035_valid", 64'(fifo_o_valid_1), 64'd0);
    check("r035_pc",    64'(fifo_o_pc_1), 64'd0);

    // Asynchronous reset between edges
    repeat (2) cyc_gen(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    check("r036_count4", 64'(count), 64'd4);
    #1 rst = 1'b0;
    #1;
    sb.delete();
    check_outputs();
    rst = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 32'hABCD_0000, 32'h1111_2222, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    check("r036_head", 64'(fifo_o_pc_1), 64'hABCD_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc_gen(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 40) == 0));
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
